// File: rtl/muldiv_sequencer.sv
// Starts the multiplier or divisor, waits for the selected done flag under a watchdog,
// then loads HI/LO and reports done / div_zero / timeout as single-cycle Moore pulses.
module muldiv_sequencer #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req,
  input  logic             op,
  input  logic             mult_fim,
  input  logic             div_fim,
  input  logic             DividedByZero,
  output logic             mult_start,
  output logic             div_start,
  output logic             HISelector,
  output logic             LOSelector,
  output logic             RegHIWrite,
  output logic             RegLOWrite,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_EXC   = 3'd5,
    S_ABORT = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cycles;
  logic             w_sel_fim;
  logic             w_zero_div;
  logic             w_cnt_last;

  assign w_sel_fim  = r_op ? div_fim : mult_fim;
  assign w_zero_div = r_op & DividedByZero;
  assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign cycles     = r_cycles;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // WAIT priority: divide-by-zero, then completion, then watchdog expiry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op     <= 1'b0;
      r_cnt    <= '0;
      r_cycles <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) r_op <= op;
        end
        S_START: begin
          r_cnt <= '0;
        end
        S_WAIT: begin
          if (!w_zero_div) begin
            if (w_sel_fim) begin
              r_cycles <= r_cnt + CNT_W'(1);
            end else if (!w_cnt_last) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    mult_start = 1'b0;
    div_start  = 1'b0;
    RegHIWrite = 1'b0;
    RegLOWrite = 1'b0;
    done       = 1'b0;
    div_zero   = 1'b0;
    timeout    = 1'b0;
    busy       = (r_state != S_IDLE);
    HISelector = (r_state != S_IDLE) & r_op;
    LOSelector = (r_state != S_IDLE) & r_op;
    case (r_state)
      S_IDLE: begin
        if (req) w_next = S_START;
      end
      S_START: begin
        mult_start = ~r_op;
        div_start  = r_op;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        if (w_zero_div)      w_next = S_EXC;
        else if (w_sel_fim)  w_next = S_WRITE;
        else if (w_cnt_last) w_next = S_ABORT;
      end
      S_WRITE: begin
        RegHIWrite = 1'b1;
        RegLOWrite = 1'b1;
        w_next     = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      S_EXC: begin
        div_zero = 1'b1;
        w_next   = S_IDLE;
      end
      S_ABORT: begin
        timeout = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: mult/div success, divide-by-zero, watchdog,
// stray flags, back-to-back requests and mid-operation reset.
module tb_muldiv_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       req, op, mult_fim, div_fim, DividedByZero;
  logic       mult_start, div_start, HISelector, LOSelector;
  logic       RegHIWrite, RegLOWrite, busy, done, div_zero, timeout;
  logic [5:0] cycles;

  int n_vec = 0;
  int n_err = 0;

  int c_ms = 0, c_ds = 0, c_wr = 0, c_done = 0, c_dz = 0, c_to = 0, c_busy = 0, c_both = 0;
  int b_ms, b_ds, b_wr, b_done, b_dz, b_to, b_busy;

  muldiv_sequencer #(.TIMEOUT(40), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .req(req), .op(op),
    .mult_fim(mult_fim), .div_fim(div_fim), .DividedByZero(DividedByZero),
    .mult_start(mult_start), .div_start(div_start),
    .HISelector(HISelector), .LOSelector(LOSelector),
    .RegHIWrite(RegHIWrite), .RegLOWrite(RegLOWrite),
    .busy(busy), .done(done), .div_zero(div_zero), .timeout(timeout),
    .cycles(cycles)
  );

  always #5 clock = ~clock;

  // Per-cycle pulse/occupancy counters, sampled on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      c_ms   = c_ms   + int'(mult_start);
      c_ds   = c_ds   + int'(div_start);
      c_wr   = c_wr   + int'(RegHIWrite | RegLOWrite);
      c_done = c_done + int'(done);
      c_dz   = c_dz   + int'(div_zero);
      c_to   = c_to   + int'(timeout);
      c_busy = c_busy + int'(busy);
      c_both = c_both + int'(mult_start & div_start);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic snap();
    b_ms = c_ms; b_ds = c_ds; b_wr = c_wr; b_done = c_done;
    b_dz = c_dz; b_to = c_to; b_busy = c_busy;
  endtask

  function automatic logic [15:0] all_outs();
    return {mult_start, div_start, HISelector, LOSelector, RegHIWrite, RegLOWrite,
            busy, done, div_zero, timeout, cycles};
  endfunction

  initial begin
    reset = 1'b1; req = 1'b0; op = 1'b0;
    mult_fim = 1'b0; div_fim = 1'b0; DividedByZero = 1'b0;
    #2;
    chk("reset_outs", 32'(all_outs()), 32'h0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'h0);

    // Mult completing in WAIT cycle 33
    snap();
    req = 1'b1; op = 1'b0;
    step();
    chk("m1_mult_start", 32'(mult_start), 32'h1);
    chk("m1_div_start", 32'(div_start), 32'h0);
    req = 1'b0;
    step();
    for (int k = 1; k < 33; k++) step();
    chk("m1_wait_busy", 32'(busy), 32'h1);
    mult_fim = 1'b1;
    step();
    mult_fim = 1'b0;
    chk("m1_write", 32'({RegHIWrite, RegLOWrite, HISelector, LOSelector}), 32'b1100);
    chk("m1_cycles", 32'(cycles), 32'd33);
    step();
    chk("m1_done", 32'({done, RegHIWrite}), 32'b10);
    step();
    chk("m1_idle", 32'({busy, done}), 32'b00);
    chk("m1_busy_cnt", 32'(c_busy - b_busy), 32'd36);
    chk("m1_ms_cnt", 32'(c_ms - b_ms), 32'd1);
    chk("m1_wr_cnt", 32'(c_wr - b_wr), 32'd1);
    chk("m1_done_cnt", 32'(c_done - b_done), 32'd1);

    // Div, zero divisor together with div_fim in WAIT cycle 2
    snap();
    req = 1'b1; op = 1'b1;
    step();
    req = 1'b0;
    chk("dz_div_start", 32'({div_start, mult_start, HISelector}), 32'b101);
    step();
    step();
    DividedByZero = 1'b1; div_fim = 1'b1;
    step();
    DividedByZero = 1'b0; div_fim = 1'b0;
    chk("dz_exc", 32'({div_zero, RegHIWrite, done}), 32'b100);
    chk("dz_cycles_held", 32'(cycles), 32'd33);
    step();
    chk("dz_idle", 32'({busy, div_zero, HISelector, LOSelector}), 32'b0000);
    chk("dz_wr_cnt", 32'(c_wr - b_wr), 32'd0);
    chk("dz_done_cnt", 32'(c_done - b_done), 32'd0);
    chk("dz_pulse_cnt", 32'(c_dz - b_dz), 32'd1);

    // Div watchdog: no div_fim for 40 WAIT cycles
    snap();
    req = 1'b1; op = 1'b1;
    step();
    req = 1'b0;
    step();
    for (int k = 1; k < 40; k++) step();
    chk("to_wait40", 32'({busy, timeout}), 32'b10);
    step();
    chk("to_abort", 32'({timeout, RegHIWrite}), 32'b10);
    chk("to_cycles_held", 32'(cycles), 32'd33);
    step();
    chk("to_idle", 32'({busy, timeout}), 32'b00);
    chk("to_busy_cnt", 32'(c_busy - b_busy), 32'd42);
    chk("to_pulse_cnt", 32'(c_to - b_to), 32'd1);
    chk("to_wr_cnt", 32'(c_wr - b_wr), 32'd0);

    // Div with div_fim in WAIT cycle 40: completion beats watchdog
    req = 1'b1; op = 1'b1;
    step();
    req = 1'b0;
    step();
    for (int k = 1; k < 40; k++) step();
    div_fim = 1'b1;
    step();
    div_fim = 1'b0;
    chk("tw_write", 32'({RegHIWrite, RegLOWrite, HISelector, LOSelector, timeout}), 32'b11110);
    chk("tw_cycles", 32'(cycles), 32'd40);
    step();
    chk("tw_done", 32'(done), 32'h1);
    step();

    // Mult with stray div flags, plus an ignored req while busy
    snap();
    req = 1'b1; op = 1'b0;
    step();
    req = 1'b0;
    step();
    for (int k = 1; k < 5; k++) begin
      div_fim = k[0]; DividedByZero = ~k[0];
      if (k == 2) begin req = 1'b1; op = 1'b1; end
      else req = 1'b0;
      step();
    end
    req = 1'b0;
    mult_fim = 1'b1; div_fim = 1'b1; DividedByZero = 1'b1;
    step();
    mult_fim = 1'b0; div_fim = 1'b0; DividedByZero = 1'b0;
    chk("sf_write", 32'({RegHIWrite, HISelector, div_zero}), 32'b100);
    chk("sf_cycles", 32'(cycles), 32'd5);
    step();
    chk("sf_done", 32'(done), 32'h1);
    step();
    step();
    chk("sf_no_queue", 32'({busy, 6'(c_ds - b_ds)}), 32'h0);

    // req held high: back-to-back divs, each completing in WAIT cycle 1
    snap();
    req = 1'b1; op = 1'b1; div_fim = 1'b1;
    for (int k = 0; k < 15; k++) step();
    chk("bb_idle_again", 32'(busy), 32'h0);
    req = 1'b0; div_fim = 1'b0;
    step();
    chk("bb_div_starts", 32'(c_ds - b_ds), 32'd3);
    chk("bb_done_cnt", 32'(c_done - b_done), 32'd3);
    chk("bb_mult_starts", 32'(c_ms - b_ms), 32'd0);
    chk("bb_cycles", 32'(cycles), 32'd1);

    // Reset pulsed between edges in WAIT cycle 10
    snap();
    req = 1'b1; op = 1'b0;
    step();
    req = 1'b0;
    step();
    for (int k = 1; k < 10; k++) step();
    #2 reset = 1'b1;
    #1;
    chk("rs_outs", 32'(all_outs()), 32'h0);
    #2;
    reset = 1'b0; req = 1'b1; op = 1'b0;
    step();
    req = 1'b0;
    chk("rs_no_write", 32'({6'(c_wr - b_wr), 6'(c_done - b_done), 6'(c_to - b_to)}), 32'h0);
    chk("rs_restart", 32'({mult_start, busy}), 32'b11);
    step();
    mult_fim = 1'b1;
    step();
    mult_fim = 1'b0;
    chk("rs_write", 32'({RegHIWrite, RegLOWrite}), 32'b11);
    chk("rs_cycles", 32'(cycles), 32'd1);
    step();
    chk("rs_done", 32'(done), 32'h1);
    step();
    chk("rs_idle", 32'(busy), 32'h0);

    chk("never_both_starts", 32'(c_both), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequencer for the multiply/divide resources of the multicycle CPU. It starts `multiplier` or `divisor` on request from `Controle` and waits for the selected unit's completion flag. On success it steers and loads the HI and LO registers. It reports completion, divide-by-zero, and a watchdog timeout back to `Controle` as single-cycle pulses, so `Controle` only issues a request and waits.

## Interface
- `TIMEOUT`, 40: maximum number of WAIT cycles before the operation is aborted; must be ≥ 2.
- `CNT_W`, 6: width of the cycle counter; requires 2^CNT_W > TIMEOUT.

- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  operation request from `Controle`; sampled only in IDLE.
- `op`  in  1  0 = mult, 1 = div; sampled together with `req`.
- `mult_fim`  in  1  multiplier done flag.
- `div_fim`  in  1  divisor done flag.
- `DividedByZero`  in  1  divisor zero-divisor flag.
- `mult_start`  out  1  multiplier start pulse.
- `div_start`  out  1  divisor start pulse.
- `HISelector`  out  1  HI source mux select: 0 = MultHI, 1 = DivHI.
- `LOSelector`  out  1  LO source mux select: 0 = MultLO, 1 = DivLO.
- `RegHIWrite`  out  1  HI register load enable.
- `RegLOWrite`  out  1  LO register load enable.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle success pulse.
- `div_zero`  out  1  one-cycle divide-by-zero exception pulse.
- `timeout`  out  1  one-cycle watchdog abort pulse.
- `cycles`  out  CNT_W  number of WAIT cycles taken by the last successful operation.

## Operation
- The FSM has seven states: IDLE, START, WAIT, WRITE, DONE, EXC, ABORT. All outputs except `cycles` are Moore-decoded from the state register.
- The block also holds `op_r` (latched operation), `cnt` (WAIT-cycle counter) and `cycles_r`.
- **IDLE**
  - If `req` = 1 at a clock edge: `op_r` ← `op`, go to START.
  - Otherwise stay in IDLE.
- **START** (always 1 cycle)
  - `mult_start` = ~`op_r`; `div_start` = `op_r`.
  - `cnt` ← 0; go to WAIT.
- **WAIT**: at each edge, check the following in priority order.
  1. `op_r` = 1 and `DividedByZero` = 1: go to EXC.
  2. The selected done flag (`mult_fim` if `op_r` = 0, `div_fim` if `op_r` = 1) is 1: `cycles_r` ← `cnt` + 1, go to WRITE.
  3. `cnt` = TIMEOUT−1: go to ABORT.
  4. Otherwise: `cnt` ← `cnt` + 1, stay in WAIT.
- The done flag of the non-selected unit is ignored.
- `DividedByZero` is ignored during a mult.
- **WRITE** (1 cycle): `RegHIWrite` = `RegLOWrite` = 1; go to DONE.
- **DONE** (1 cycle): `done` = 1; go to IDLE.
- **EXC** (1 cycle): `div_zero` = 1; go to IDLE. HI and LO are not written.
- **ABORT** (1 cycle): `timeout` = 1; go to IDLE. HI and LO are not written.
- `HISelector` = `LOSelector` = `op_r` in every state except IDLE, where both are 0.
- `cycles` = `cycles_r`. It is updated only on the WAIT→WRITE transition and is held through EXC and ABORT.
- `req` asserted in any state other than IDLE is ignored; it is not queued.

## Timing
- Edges are numbered E0, E1, …; "after E*n*" means the cycle following edge E*n*.
- Request:
  - `req` = 1 at E0 (in IDLE) → START after E0 → WAIT after E1.
  - `cnt` = 0 in the first WAIT cycle.
- Success:
  - Selected done flag first sampled high at edge E(1+m), after m WAIT cycles → WRITE after E(1+m), DONE after E(2+m), IDLE after E(3+m).
  - `cycles` = m from E(1+m) onward.
  - `busy` is high for m+3 cycles.
  - A new `req` can be accepted at E(3+m).
- Minimum latency: done flag already high in the first WAIT cycle (m = 1) → `done` 3 cycles after START.
- Timeout:
  - The watchdog aborts after exactly TIMEOUT WAIT cycles, with ABORT in the cycle after the edge where `cnt` = TIMEOUT−1.
  - A done flag sampled at that same edge wins, giving WRITE instead of ABORT.
- Simultaneous `DividedByZero` and `div_fim` at the same edge → EXC.
- Reset:
  - State → IDLE; `op_r`, `cnt` and `cycles_r` → 0.
  - Every output is 0 immediately on reset assertion, without waiting for a clock.
  - Reset in the middle of an operation abandons it with no HI/LO write and no pulse.
  - The first `req` is accepted at the first edge after `reset` is released.
- `mult_start` and `div_start` never assert together. Each is high for exactly 1 cycle per accepted request.

## Test plan
- Mult, `mult_fim` at the 33rd WAIT cycle → `mult_start` for 1 cycle, `RegHIWrite`/`RegLOWrite` = 1 with both selectors = 0 for 1 cycle, `done` pulse, `cycles` = 33, `busy` high for 36 cycles.
- Div with `DividedByZero` = 1 in the 2nd WAIT cycle, together with `div_fim` = 1 → `div_zero` pulse, no HI/LO write, `done` stays 0, `cycles` unchanged.
- Div with `TIMEOUT` = 40 and `div_fim` never asserted → `timeout` pulse after exactly 40 WAIT cycles, then IDLE. Variant with `div_fim` = 1 in WAIT cycle 40 → WRITE and `cycles` = 40.
- Mult with `div_fim` and `DividedByZero` toggling and `mult_fim` arriving at WAIT cycle 5 → the stray flags are ignored, a normal write occurs, `cycles` = 5.
- `req` held high continuously with `op` = 1 → back-to-back divs, one `div_start` per operation. Requests during busy are not queued.
- `reset` pulsed in WAIT cycle 10, between clock edges → all outputs 0 immediately, no write and no pulse. A subsequent mult completes normally.
